// File: rtl/calc_display_if.sv
// Bus between the calculator and the display driver: the word to show plus the
// strobe that captures it, and the multiplexed 7-segment drive coming back.
interface calc_display_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (output value, load, input an, seg, dp, frame_done);
  modport slave  (input value, load, output an, seg, dp, frame_done);
endinterface

// File: rtl/calc_display.sv
// Shows a captured 16-bit word as four hex digits on a time-multiplexed,
// common-anode 7-segment display, with optional leading-zero blanking.
module calc_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  calc_display_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

  digit_e          state_q, state_d;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     dispVal_q, dispVal_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q;
  logic            frameDone_q, frameDone_d;
  logic            lastTick;
  logic [15:0]     upper;
  logic            blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign idx = state_q;

  // A digit above position 0 is blank when it and every digit to its left are zero.
  always_comb begin
    lastTick    = (cnt_q == CW'(REFRESH_DIV - 1));
    dispVal_d   = bus.load ? bus.value : dispVal_q;
    cnt_d       = lastTick ? '0 : cnt_q + CW'(1);
    state_d     = lastTick ? digit_e'(idx + 2'd1) : state_q;
    frameDone_d = lastTick && (state_q == DIG3);
    upper       = dispVal_q >> {idx, 2'b00};
    blank       = BLANK_LZ && (idx != 2'd0) && (upper == 16'h0000);
    an_d        = ~(4'b0001 << idx);
    seg_d       = blank ? 7'h7F : hex7(upper[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIG0;
      cnt_q       <= '0;
      dispVal_q   <= 16'h0000;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dispVal_q   <= dispVal_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= 1'b1;
      frameDone_q <= frameDone_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_calc_display.sv
// Bench for calc_display: two instances (blanking on/off) fed the same stimulus,
// checked against a digit-position model and a table of hand-derived vectors.
module tb_calc_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_display_if ifA();
  calc_display_if ifB();

  calc_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  calc_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] value;
    int          reps;
    logic [3:0]  an;
    logic [6:0]  segA;
    logic [6:0]  segB;
    logic        fd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model: elapsed non-reset cycles and the captured word.
  int          mCycles = 0;
  logic [15:0] mVal = 16'h0000;
  logic [3:0]  expAn;
  logic [6:0]  expSegA, expSegB;
  logic        expFd;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    cmp({name, ".anA"}, 16'(ifA.an), 16'(expAn));
    cmp({name, ".anB"}, 16'(ifB.an), 16'(expAn));
    cmp({name, ".segA"}, 16'(ifA.seg), 16'(expSegA));
    cmp({name, ".segB"}, 16'(ifB.seg), 16'(expSegB));
    cmp({name, ".dpA"}, 16'(ifA.dp), 16'd1);
    cmp({name, ".dpB"}, 16'(ifB.dp), 16'd1);
    cmp({name, ".fdA"}, 16'(ifA.frame_done), 16'(expFd));
    cmp({name, ".fdB"}, 16'(ifB.frame_done), 16'(expFd));
  endtask

  task automatic expectNow(input string name, input logic [3:0] an, input logic [6:0] segA,
                           input logic [6:0] segB, input logic fd);
    cmp({name, ".anA"}, 16'(ifA.an), 16'(an));
    cmp({name, ".anB"}, 16'(ifB.an), 16'(an));
    cmp({name, ".segA"}, 16'(ifA.seg), 16'(segA));
    cmp({name, ".segB"}, 16'(ifB.seg), 16'(segB));
    cmp({name, ".fdA"}, 16'(ifA.frame_done), 16'(fd));
    cmp({name, ".fdB"}, 16'(ifB.frame_done), 16'(fd));
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v);
    int d;
    int nib;
    @(negedge clk);
    rst = r;
    ifA.load = l; ifA.value = v;
    ifB.load = l; ifB.value = v;
    if (r) begin
      expAn = 4'hF; expSegA = 7'h7F; expSegB = 7'h7F; expFd = 1'b0;
    end else begin
      d = (mCycles / 4) % 4;
      nib = (int'(mVal) >> (4 * d)) % 16;
      expAn = 4'(15 - (1 << d));
      expSegB = HEX[nib];
      expSegA = (d > 0 && int'(mVal) < (1 << (4 * d))) ? 7'h7F : HEX[nib];
      expFd = (mCycles % 16 == 15);
    end
    @(posedge clk);
    if (r) begin
      mVal = 16'h0000;
      mCycles = 0;
    end else begin
      if (l) mVal = v;
      mCycles++;
    end
    #1;
    checkOutput("model");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    ifA.load = 1'b0; ifA.value = 16'h0000;
    ifB.load = 1'b0; ifB.value = 16'h0000;

    vecs.push_back('{1'b1, 1'b0, 16'h0000, 3, 4'hF, 7'h7F, 7'h7F, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'h1A3F, 1, 4'hE, 7'h40, 7'h40, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 3, 4'hE, 7'h0E, 7'h0E, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 4, 4'hD, 7'h30, 7'h30, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 4, 4'hB, 7'h08, 7'h08, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 3, 4'h7, 7'h79, 7'h79, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1, 4'h7, 7'h79, 7'h79, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 4, 4'hE, 7'h0E, 7'h0E, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 4, 4'hD, 7'h30, 7'h30, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 4, 4'hB, 7'h08, 7'h08, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 3, 4'h7, 7'h79, 7'h79, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 1, 4'h7, 7'h79, 7'h79, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].value);
        expectNow($sformatf("vec%0d.%0d", i, k), vecs[i].an, vecs[i].segA, vecs[i].segB, vecs[i].fd);
      end
    end

    // Leading-zero blanking on 0005
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0005);
    idle(1);
    expectNow("lz5.d0", 4'hE, 7'h12, 7'h12, 1'b0);
    idle(3);
    expectNow("lz5.d1", 4'hD, 7'h7F, 7'h40, 1'b0);
    idle(4);
    expectNow("lz5.d2", 4'hB, 7'h7F, 7'h40, 1'b0);
    idle(4);
    expectNow("lz5.d3", 4'h7, 7'h7F, 7'h40, 1'b0);

    // Zero value still shows digit 0, then a load lands mid-scan on digit 1
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    idle(1);
    expectNow("zero.d0", 4'hE, 7'h40, 7'h40, 1'b0);
    idle(3);
    expectNow("zero.d1", 4'hD, 7'h7F, 7'h40, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h00F0);
    expectNow("midload.before", 4'hD, 7'h7F, 7'h40, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    expectNow("midload.after", 4'hD, 7'h0E, 7'h0E, 1'b0);

    // Reset at digit 2, count 2
    idle(3);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    expectNow("midreset", 4'hF, 7'h7F, 7'h7F, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    expectNow("midreset.release", 4'hE, 7'h40, 7'h40, 1'b0);

    // Reset wins over a simultaneous load
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    expectNow("rstload", 4'hF, 7'h7F, 7'h7F, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    expectNow("rstload.release", 4'hE, 7'h40, 7'h40, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) == 0, $urandom_range(3) == 0, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
